// File: rtl/stack_cmd_frontend.sv
// Command front-end for the two-phase LIFO stack: synchronises and debounces the
// raw switches, turns each press into a phase-aligned 2-cycle push/pop and tracks occupancy.
module stack_cmd_frontend #(
  parameter int DEPTH    = 256,
  parameter int DEBOUNCE = 4,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_sw,
  input  logic          pop_sw,
  input  logic [7:0]    data_sw,
  input  logic          clr_err,
  output logic          push,
  output logic          pop,
  output logic [7:0]    data_out,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_overflow,
  output logic          err_underflow,
  output logic          busy,
  output logic [1:0]    dbg_state,
  output logic          dbg_phase
);

  localparam int DBW = $clog2(DEBOUNCE) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD0 = 2'd1;
  localparam logic [1:0] S_HOLD1 = 2'd2;

  // Bit 0 of the switch vectors is push, bit 1 is pop.
  logic [1:0]     sw_s1_q, sw_s2_q, db_q, db_prev_q, pend_q, pend_d, pend_clr, edge_det;
  logic [DBW-1:0] dbc_q [2];
  logic [7:0]     data_s1_q, data_s2_q, data_q, data_d;
  logic [1:0]     state_q, state_d;
  logic           phase_q;
  logic           push_q, push_d, pop_q, pop_d;
  logic [CW-1:0]  count_q, count_d, cnt_now;
  logic           err_ov_q, err_un_q, ov_set, un_set, launch_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) dbc_q[i] <= '0;
    end else begin
      sw_s1_q   <= {pop_sw, push_sw};
      sw_s2_q   <= sw_s1_q;
      data_s1_q <= data_sw;
      data_s2_q <= data_s1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sw_s2_q[i] != db_q[i]) begin
          if (dbc_q[i] == DBW'(DEBOUNCE - 1)) begin
            db_q[i]  <= sw_s2_q[i];
            dbc_q[i] <= '0;
          end else begin
            dbc_q[i] <= dbc_q[i] + 1'b1;
          end
        end else begin
          dbc_q[i] <= '0;
        end
      end
    end
  end

  assign edge_det = db_q & ~db_prev_q;

  // Command protocol: push/pop are registered and stay high for exactly two cycles,
  // the first on stack step 0 and the second on step 1. The launch decision is made on
  // a phase-1 cycle (IDLE or HOLD1) so the registered command lands on step 0.
  always_comb begin
    state_d   = state_q;
    push_d    = push_q;
    pop_d     = pop_q;
    data_d    = data_q;
    count_d   = count_q;
    cnt_now   = count_q;
    pend_clr  = '0;
    ov_set    = 1'b0;
    un_set    = 1'b0;
    launch_ok = 1'b0;
    case (state_q)
      S_IDLE:  launch_ok = phase_q;
      S_HOLD0: state_d = S_HOLD1;
      S_HOLD1: begin
        if (push_q)     cnt_now = count_q + 1'b1;
        else if (pop_q) cnt_now = count_q - 1'b1;
        count_d   = cnt_now;
        push_d    = 1'b0;
        pop_d     = 1'b0;
        state_d   = S_IDLE;
        launch_ok = phase_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (launch_ok) begin
      if (pend_q[0]) begin
        pend_clr[0] = 1'b1;
        if (cnt_now == CW'(DEPTH)) begin
          ov_set = 1'b1;
        end else begin
          push_d  = 1'b1;
          data_d  = data_s2_q;
          state_d = S_HOLD0;
        end
      end else if (pend_q[1]) begin
        pend_clr[1] = 1'b1;
        if (cnt_now == '0) begin
          un_set = 1'b1;
        end else begin
          pop_d   = 1'b1;
          state_d = S_HOLD0;
        end
      end
    end
    // A new press in the same cycle as a launch stays pending.
    pend_d = (pend_q & ~pend_clr) | edge_det;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      err_ov_q <= 1'b0;
      err_un_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= ~phase_q;
      push_q   <= push_d;
      pop_q    <= pop_d;
      data_q   <= data_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      err_ov_q <= (err_ov_q & ~clr_err) | ov_set;
      err_un_q <= (err_un_q & ~clr_err) | un_set;
    end
  end

  assign push          = push_q;
  assign pop           = pop_q;
  assign data_out      = data_q;
  assign count         = count_q;
  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;
  assign dbg_phase     = phase_q;

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// Bench for stack_cmd_frontend: randomized presses against an occupancy model,
// expected commands/errors queued by the driver and consumed by an output monitor.
module tb_stack_cmd_frontend;
  localparam int DEPTH    = 4;
  localparam int DEBOUNCE = 4;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_sw = 1'b0, pop_sw = 1'b0, clr_err = 1'b0;
  logic [7:0]    data_sw = 8'h00;
  logic          push, pop, full, empty, err_overflow, err_underflow, busy, dbg_phase;
  logic [7:0]    data_out;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;

  stack_cmd_frontend #(.DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .push_sw(push_sw), .pop_sw(pop_sw), .data_sw(data_sw),
    .clr_err(clr_err), .push(push), .pop(pop), .data_out(data_out), .count(count),
    .full(full), .empty(empty), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .busy(busy), .dbg_state(dbg_state), .dbg_phase(dbg_phase)
  );

  // clock / reset-relative cycle index
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // scoreboard state: {kind, data}; kind 0=push cmd, 1=pop cmd, 2=overflow, 3=underflow
  logic [9:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int occ = 0;
  int push_start = -1;
  int pop_start = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_exp(input logic [1:0] kind, input logic [7:0] d, input string name,
                         output logic [7:0] exp_d);
    logic [9:0] e;
    exp_d = 8'h00;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event kind %0d, nothing expected", name, kind);
    end else begin
      e = exp_q.pop_front();
      exp_d = e[7:0];
      check({name, "_kind"}, 32'(kind), 32'(e[9:8]));
      if (e[9:8] == 2'd0) check({name, "_data"}, 32'(d), 32'(e[7:0]));
    end
  endtask

  // monitor
  logic prev_push = 1'b0, prev_pop = 1'b0, prev_ov = 1'b0, prev_un = 1'b0;
  logic [7:0] cur_data = 8'h00;
  logic [7:0] dummy;
  int push_len = 0, pop_len = 0;

  always @(negedge clk) begin
    if (push && !prev_push) begin
      pop_exp(2'd0, data_out, "push_cmd", cur_data);
      check("push_phase", 32'(cyc % 2), 0);
      push_start = cyc;
      push_len = 0;
    end
    if (push) begin
      push_len++;
      check("push_data_hold", 32'(data_out), 32'(cur_data));
    end else if (prev_push) begin
      check("push_len", 32'(push_len), 2);
    end
    if (pop && !prev_pop) begin
      pop_exp(2'd1, 8'h00, "pop_cmd", dummy);
      check("pop_phase", 32'(cyc % 2), 0);
      pop_start = cyc;
      pop_len = 0;
    end
    if (pop) pop_len++;
    else if (prev_pop) check("pop_len", 32'(pop_len), 2);
    if (err_overflow && !prev_ov)  pop_exp(2'd2, 8'h00, "overflow", dummy);
    if (err_underflow && !prev_un) pop_exp(2'd3, 8'h00, "underflow", dummy);
    prev_push = push;
    prev_pop  = pop;
    prev_ov   = err_overflow;
    prev_un   = err_underflow;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_state(input string tag);
    @(negedge clk);
    check({tag, "_count"}, 32'(count), 32'(occ));
    check({tag, "_full"}, 32'(full), 32'(occ == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(occ == 0));
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    push_sw = 1'b0;
    pop_sw = 1'b0;
    clr_err = 1'b0;
    data_sw = 8'h00;
    tick(3);
    reset = 1'b0;
    occ = 0;
    exp_q.delete();
    @(negedge clk);
    check("rst_push", 32'(push), 0);
    check("rst_pop", 32'(pop), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_err_ov", 32'(err_overflow), 0);
    check("rst_err_un", 32'(err_underflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_phase", 32'(dbg_phase), 0);
  endtask

  task automatic press(input bit dp, input bit dq, input logic [7:0] d);
    int nb;
    bit err;
    err = 1'b0;
    data_sw = d;
    nb = 2 * $urandom_range(0, 3);
    for (int i = 0; i < nb; i++) begin
      push_sw = dp & (i % 2 == 0);
      pop_sw  = dq & (i % 2 == 0);
      tick(1);
    end
    if (dp) begin
      if (occ == DEPTH) begin exp_q.push_back({2'd2, 8'h00}); err = 1'b1; end
      else begin exp_q.push_back({2'd0, d}); occ++; end
    end
    if (dq) begin
      if (occ == 0) begin exp_q.push_back({2'd3, 8'h00}); err = 1'b1; end
      else begin exp_q.push_back({2'd1, 8'h00}); occ--; end
    end
    push_sw = dp;
    pop_sw  = dq;
    tick(14);
    push_sw = 1'b0;
    pop_sw  = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL press_timeout: %0d expected events never seen", exp_q.size());
      exp_q.delete();
    end
    tick(DEBOUNCE + 6);
    check_idle_state("press");
    if (err) begin
      @(posedge clk); #1;
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      @(negedge clk);
      check("clr_err_ov", 32'(err_overflow), 0);
      check("clr_err_un", 32'(err_underflow), 0);
    end
  endtask

  initial begin
    bit found;
    bit rp, rq;
    tick(2);
    apply_reset();

    // underflow on empty, then cleared
    press(1'b0, 1'b1, 8'h00);
    press(1'b1, 1'b0, 8'hA5);
    press(1'b1, 1'b0, 8'h3C);
    press(1'b1, 1'b0, 8'h5A);

    // simultaneous push and pop at count 3: push first, pop two cycles later
    press(1'b1, 1'b1, 8'hC3);
    check("back_to_back_gap", 32'(pop_start - push_start), 2);

    // fill to DEPTH, overflow, then pop
    press(1'b1, 1'b0, 8'h11);
    press(1'b1, 1'b0, 8'h22);
    press(1'b0, 1'b1, 8'h00);

    // bounce only, never stable long enough: no command
    for (int i = 0; i < 10; i++) begin
      push_sw = (i % 2 == 0);
      tick(1);
    end
    push_sw = 1'b0;
    tick(20);
    check_idle_state("bounce_only");

    for (int n = 0; n < 30; n++) begin
      rp = 1'(($urandom_range(0, 9) < 6));
      rq = 1'(($urandom_range(0, 9) < 5));
      if (!rp && !rq) rq = 1'b1;
      press(rp, rq, 8'($urandom_range(0, 255)));
    end

    // reset asserted during HOLD1 of a push
    apply_reset();
    data_sw = 8'h77;
    exp_q.push_back({2'd0, 8'h77});
    push_sw = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (push) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL hold_abort_launch: push never launched");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    push_sw = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    occ = 0;
    exp_q.delete();
    @(negedge clk);
    check("abort_push", 32'(push), 0);
    check("abort_count", 32'(count), 0);
    check("abort_phase", 32'(dbg_phase), 0);
    press(1'b1, 1'b0, 8'h99);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
